display_scan_ctrl: RTL and testbench

- Time-multiplexes NUM_DIGITS 4-bit display codes through the single shared 7-segment decoder and drives one-hot digit selects.
- Codes follow the decoder map: 0-9 digits, 10 blank, 11 dash, 12 'A', 13 'P'.
- Adds inter-digit blanking (ghost suppression), a tear-free shadow update handshake and per-digit blinking.
- Sits between the clock/alarm time-keeping logic and the decoder/anode pins.

---
 rtl/display_pkg.sv | 21 ++
 rtl/display_scan_ctrl_if.sv | 22 ++
 rtl/display_scan_ctrl_scan_blink_timer.sv | 34 +++
 rtl/display_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared display constants: decoder code map and scan FSM state encoding.
// Used by the scan controller, the 7-segment decoder and the time-keeping logic.
package display_pkg;

   localparam logic [3:0] CODE_BLANK = 4'd10;
   localparam logic [3:0] CODE_DASH  = 4'd11;
   localparam logic [3:0] CODE_A     = 4'd12;
   localparam logic [3:0] CODE_P     = 4'd13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } scan_state_e;

   // Counter width able to hold 0..v-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 32'd2) ? 32'd1 : $clog2(v);
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between the time-keeping logic (master) and the display scan controller (slave).
interface display_scan_ctrl_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      enable;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic                      update_req;
   logic [NUM_DIGITS-1:0]     blink_mask;
   logic                      update_ack;
   logic [3:0]                bch;
   logic [NUM_DIGITS-1:0]     digit_sel;

   modport master (
      output enable, digits_in, update_req, blink_mask,
      input  update_ack, bch, digit_sel
   );

   modport slave (
      input  enable, digits_in, update_req, blink_mask,
      output update_ack, bch, digit_sel
   );
endinterface

// File: rtl/display_scan_ctrl_scan_blink_timer.sv
// Counts completed scan frames and toggles the blink phase every BLINK_FRAMES frames.
module scan_blink_timer
   import display_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = 250
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_frame_wrap,
   output logic o_blink_phase,
   output logic o_toggle_c
);
   localparam int unsigned FW = clog2_min1(BLINK_FRAMES);

   logic [FW-1:0] r_frame_cnt;
   logic          r_blink_phase;

   // Lets the scan FSM see the post-edge phase when it registers digit 0 of a new frame.
   assign o_toggle_c    = i_frame_wrap && (r_frame_cnt == FW'(BLINK_FRAMES - 1));
   assign o_blink_phase = r_blink_phase;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (o_toggle_c) begin
         r_frame_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else if (i_frame_wrap) begin
         r_frame_cnt   <= r_frame_cnt + FW'(1);
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with inter-digit blanking, frame-aligned
// shadow update and per-digit blink. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SHOW_CYCLES  = 1000,
   parameter int unsigned BLANK_CYCLES = 50,
   parameter int unsigned BLINK_FRAMES = 250
) (
   input  logic                clk,
   input  logic                rst_n,
   display_scan_ctrl_if.slave  bus
);
   localparam int unsigned IW      = clog2_min1(NUM_DIGITS);
   localparam int unsigned CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int unsigned CW      = clog2_min1(CNT_MAX);

   typedef logic [NUM_DIGITS-1:0][3:0] codes_t;

   scan_state_e           r_state;
   logic [IW-1:0]         r_idx;
   logic [CW-1:0]         r_cnt;
   codes_t                r_staging;
   codes_t                r_shadow;
   logic                  r_pending;
   logic                  r_update_ack;
   logic [3:0]            r_bch;
   logic [NUM_DIGITS-1:0] r_digit_sel;

   logic                  w_show_last;
   logic                  w_blank_last;
   logic                  w_idx_last;
   logic                  w_frame_wrap;
   logic                  w_xfer;
   logic [IW-1:0]         w_idx_nxt;
   codes_t                w_src;
   logic                  w_blink_phase;
   logic                  w_blink_toggle;
   logic                  w_phase_eff;

   scan_blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_frame_wrap  (w_frame_wrap),
      .o_blink_phase (w_blink_phase),
      .o_toggle_c    (w_blink_toggle)
   );

   assign w_show_last  = (r_cnt == CW'(SHOW_CYCLES - 1));
   assign w_blank_last = (r_cnt == CW'(BLANK_CYCLES - 1));
   assign w_idx_last   = (r_idx == IW'(NUM_DIGITS - 1));
   assign w_idx_nxt    = w_idx_last ? '0 : r_idx + IW'(1);
   assign w_frame_wrap = bus.enable && (r_state == BLANK) && w_blank_last && w_idx_last;
   assign w_xfer       = r_pending && (w_frame_wrap || (r_state == IDLE));
   // On a transfer edge the newly shown digit must already come from the staged frame.
   assign w_src        = w_xfer ? r_staging : r_shadow;
   assign w_phase_eff  = w_blink_phase ^ w_blink_toggle;

   function automatic logic [3:0] digit_code(input codes_t src, input logic [IW-1:0] idx,
                                             input logic phase, input logic [NUM_DIGITS-1:0] mask);
      logic [3:0] code;
      code = src[idx];
      if (!phase && mask[idx]) code = CODE_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx == IW'(NUM_DIGITS - 1)) && (src[idx] == 4'd0)) code = CODE_BLANK;
`endif
      return code;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_staging    <= {NUM_DIGITS{CODE_BLANK}};
         r_shadow     <= {NUM_DIGITS{CODE_BLANK}};
         r_pending    <= 1'b0;
         r_update_ack <= 1'b0;
         r_bch        <= CODE_BLANK;
         r_digit_sel  <= '0;
      end else begin
         r_update_ack <= w_xfer;
         if (w_xfer) r_shadow <= r_staging;
         // A request coinciding with a transfer stays pending for the next boundary.
         if (bus.update_req) begin
            r_staging <= bus.digits_in;
            r_pending <= 1'b1;
         end else if (w_xfer) begin
            r_pending <= 1'b0;
         end

         if (!bus.enable) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_bch       <= CODE_BLANK;
            r_digit_sel <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state     <= SHOW;
                  r_idx       <= '0;
                  r_cnt       <= '0;
                  r_digit_sel <= NUM_DIGITS'(1);
                  r_bch       <= digit_code(w_src, '0, w_phase_eff, bus.blink_mask);
               end
               SHOW: begin
                  if (w_show_last) begin
                     r_state     <= BLANK;
                     r_cnt       <= '0;
                     r_digit_sel <= '0;
                     r_bch       <= CODE_BLANK;
                  end else begin
                     r_cnt       <= r_cnt + CW'(1);
                     r_bch       <= digit_code(w_src, r_idx, w_phase_eff, bus.blink_mask);
                  end
               end
               BLANK: begin
                  if (w_blank_last) begin
                     r_state     <= SHOW;
                     r_idx       <= w_idx_nxt;
                     r_cnt       <= '0;
                     r_digit_sel <= NUM_DIGITS'(1) << w_idx_nxt;
                     r_bch       <= digit_code(w_src, w_idx_nxt, w_phase_eff, bus.blink_mask);
                  end else begin
                     r_cnt       <= r_cnt + CW'(1);
                  end
               end
               default: begin
                  r_state     <= IDLE;
                  r_idx       <= '0;
                  r_cnt       <= '0;
                  r_bch       <= CODE_BLANK;
                  r_digit_sel <= '0;
               end
            endcase
         end
      end
   end

   assign bus.update_ack = r_update_ack;
   assign bus.bch        = r_bch;
   assign bus.digit_sel  = r_digit_sel;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a position-based scan model.
module tb_display_scan_ctrl;
   localparam int unsigned ND = 4;
   localparam int unsigned SC = 4;
   localparam int unsigned BC = 1;
   localparam int unsigned BF = 2;

   logic clk;
   logic rst_n;

   display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   display_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SHOW_CYCLES  (SC),
      .BLANK_CYCLES (BC),
      .BLINK_FRAMES (BF)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: scan position since the last start, frame wraps ever seen, and the data registers.
   int m_stg [ND];
   int m_shd [ND];
   bit m_pend;
   bit m_active;
   int m_p;
   int m_wraps;
   int e_bch, e_sel, e_ack;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_edge();
      int period;
      bit wrap, xfer;
      int slot, d, c;
      period = ND * (SC + BC);
      if (!rst_n) begin
         for (int i = 0; i < ND; i++) begin
            m_stg[i] = 10;
            m_shd[i] = 10;
         end
         m_pend = 0; m_active = 0; m_p = 0; m_wraps = 0;
         e_bch = 10; e_sel = 0; e_ack = 0;
         return;
      end
      wrap  = bus.enable && m_active && (((m_p + 1) % period) == 0);
      xfer  = m_pend && (wrap || !m_active);
      e_ack = xfer ? 1 : 0;
      if (xfer) begin
         for (int i = 0; i < ND; i++) m_shd[i] = m_stg[i];
         m_pend = 0;
      end
      if (bus.update_req) begin
         for (int i = 0; i < ND; i++) m_stg[i] = int'(bus.digits_in[4*i +: 4]);
         m_pend = 1;
      end
      if (wrap) m_wraps++;
      if (!bus.enable) begin
         m_active = 0;
         e_bch = 10; e_sel = 0;
      end else begin
         if (!m_active) begin
            m_active = 1;
            m_p = 0;
         end else begin
            m_p++;
         end
         slot = m_p % (SC + BC);
         d    = (m_p / (SC + BC)) % ND;
         if (slot < SC) begin
            e_sel = 1 << d;
            c = m_shd[d];
            if ((((m_wraps / BF) % 2) == 1) && bus.blink_mask[d]) c = 10;
`ifdef LEADING_ZERO_BLANK_EN
            if ((d == ND - 1) && (m_shd[d] == 0)) c = 10;
`endif
            e_bch = c;
         end else begin
            e_sel = 0; e_bch = 10;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("bch",        32'(bus.bch),        32'(e_bch));
      check_eq("digit_sel",  32'(bus.digit_sel),  32'(e_sel));
      check_eq("update_ack", 32'(bus.update_ack), 32'(e_ack));
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic request(input logic [4*ND-1:0] codes);
      bus.digits_in  = codes;
      bus.update_req = 1'b1;
      tick();
      bus.update_req = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.enable     = 1'b0;
      bus.update_req = 1'b0;
      bus.blink_mask = '0;
      bus.digits_in  = '0;
      run(3);
      rst_n = 1'b1;
      run(1);
      request(16'h4321);
      run(2);
      bus.enable = 1'b1;
      run(12);
      request(16'h9999);
      run(30);
      request(16'h5555);
      run(3);
      request(16'h6666);
      run(40);
      bus.blink_mask = 4'b0010;
      run(90);
      bus.blink_mask = '0;
      run(6);
      bus.enable = 1'b0;
      request(16'h8765);
      run(2);
      bus.enable = 1'b1;
      run(25);
      request(16'h0123);
      run(45);
      for (int k = 0; k < 2000; k++) begin
         rst_n          = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
         bus.update_req = ($urandom_range(0, 11) == 0);
         bus.digits_in  = 16'($urandom);
         if ($urandom_range(0, 49) == 0) bus.blink_mask = ND'($urandom);
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
